// File: rtl/conv_stream_engine.sv
// Streaming KxK signed convolution over an unsigned raster-order feature map.
// Two-stage pipeline (products, then sum/shift/ReLU/saturate) with valid/ready backpressure.
module conv_stream_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int K          = 3,
  parameter int ACC_WIDTH  = 24,
  parameter int SHIFT      = 0,
  localparam int AW        = (K * K > 1) ? $clog2(K * K) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stride2,
  input  logic                  relu_en,
  input  logic                  w_we,
  input  logic [AW-1:0]         w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int KK     = K * K;
  localparam int SR_LEN = (K - 1) * IMG_W + K;
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW     = 2 * DATA_WIDTH + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);
  localparam logic          KPAR     = 1'((K - 1) % 2);
  localparam logic [AW:0]   KK_L     = (AW + 1)'(KK);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - ACC_WIDTH'(1);

  logic [1:0]            state_q, state_d;
  logic                  stride_q, relu_q;
  logic [CW-1:0]         col_q;
  logic [RW-1:0]         row_q;
  logic [DATA_WIDTH-1:0] w_q   [KK];
  logic [DATA_WIDTH-1:0] sr_q  [SR_LEN-1];
  logic [DATA_WIDTH-1:0] nxt   [SR_LEN];
  logic signed [PW-1:0]  prod_d [KK];
  logic signed [PW-1:0]  prod_q [KK];
  logic                  v1_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_q;

  logic                  stall, accept, win_ok, last_pix, wr_ok;
  logic signed [ACC_WIDTH-1:0] sum, shifted;
  logic [DATA_WIDTH-1:0] res;

  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = (state_q == S_STREAM) && !stall;
  assign accept    = in_ready && in_valid;
  assign last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign win_ok    = (row_q >= ROW_MIN) && (col_q >= COL_MIN) &&
                     (!stride_q || ((row_q[0] == KPAR) && (col_q[0] == KPAR)));
  assign wr_ok     = w_we && ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                     ({1'b0, w_addr} < KK_L);
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign busy      = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

  // Products use the window as it will look once the incoming pixel is shifted in,
  // so stage 1 captures on the accepting edge itself.
  always_comb begin
    nxt[0] = in_data;
    for (int unsigned j = 1; j < SR_LEN; j++) nxt[j] = sr_q[j-1];
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        prod_d[r*K+c] = $signed({1'b0, nxt[(K-1-r)*IMG_W + (K-1-c)]}) * $signed(w_q[r*K+c]);
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < KK; i++) sum = sum + ACC_WIDTH'(prod_q[i]);
    shifted = sum >>> SHIFT;
    if (relu_q && (shifted < 0))  res = '0;
    else if (shifted > SAT_MAX)   res = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN)   res = SAT_MIN[DATA_WIDTH-1:0];
    else                          res = shifted[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (accept && last_pix) state_d = S_DRAIN;
      S_DRAIN:  if (!v1_q && (!out_valid_q || out_ready)) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      stride_q    <= 1'b0;
      relu_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      for (int unsigned i = 0; i < KK; i++) begin
        w_q[i]    <= '0;
        prod_q[i] <= '0;
      end
      for (int unsigned i = 0; i < SR_LEN - 1; i++) sr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && start) begin
        stride_q <= stride2;
        relu_q   <= relu_en;
        col_q    <= '0;
        row_q    <= '0;
      end
      if (accept) begin
        for (int unsigned i = 0; i < SR_LEN - 1; i++) sr_q[i] <= nxt[i];
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      if (!stall) begin
        v1_q        <= accept && win_ok;
        out_valid_q <= v1_q;
        if (accept) for (int unsigned i = 0; i < KK; i++) prod_q[i] <= prod_d[i];
        if (v1_q) out_q <= res;
      end
      if (wr_ok) w_q[w_addr] <= w_data;
    end
  end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed self-checking bench for conv_stream_engine (K=3, 8x8, 8-bit, SHIFT=0).
module tb_conv_stream_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, stride2 = 1'b0, relu_en = 1'b0;
  logic       w_we = 1'b0;
  logic [3:0] w_addr = '0;
  logic [7:0] w_data = '0;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid, out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int got[$];
  int exp_q[$];

  conv_stream_engine #(
    .DATA_WIDTH(8), .IMG_W(8), .IMG_H(8), .K(3), .ACC_WIDTH(24), .SHIFT(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stride2(stride2), .relu_en(relu_en),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // kind 0: identity (centre tap 1), 1: all +1, 2: all -1
  task automatic load_w(input int kind);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      w_we   = 1'b1;
      w_addr = 4'(i);
      w_data = (kind == 0) ? ((i == 4) ? 8'd1 : 8'd0) : (kind == 1) ? 8'd1 : 8'hFF;
    end
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic exp_ramp(input bit s2);
    exp_q.delete();
    for (int r = 0; r < 6; r += (s2 ? 2 : 1))
      for (int c = 0; c < 6; c += (s2 ? 2 : 1))
        exp_q.push_back((r + 1) * 8 + (c + 1));
  endtask

  task automatic exp_const(input int n, input int v);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // mode 0: ramp pixels, 1: all 255. disturb drives start/stride/relu/weight writes while busy.
  task automatic run_frame(input bit s2, input bit relu, input int mode, input bit rnd, input bit disturb);
    int p, cyc, acc_cyc, out_cyc;
    bit stalled, seen_done;
    logic [7:0] held;
    got.delete();
    @(negedge clk);
    start = 1'b1; stride2 = s2; relu_en = relu;
    #4 check("busy_idle", busy, 0);
    @(negedge clk);
    start = 1'b0;
    #4 check("busy_started", busy, 1);
    p = 0; cyc = 0; acc_cyc = -1; out_cyc = -1; stalled = 0; seen_done = 0; held = '0;
    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      in_valid  = (p < 64) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      in_data   = (mode == 0) ? p[7:0] : 8'hFF;
      out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (disturb) begin
        start = 1'b1; stride2 = !s2; relu_en = !relu;
        w_we = 1'b1; w_addr = 4'd4; w_data = 8'd5;
      end
      #4;
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held);
      end
      if (out_valid && out_cyc < 0) out_cyc = cyc;
      if (out_valid && out_ready) got.push_back(int'($signed(out_data)));
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (in_valid && in_ready) begin
        if (p == 18) acc_cyc = cyc;
        p++;
      end
      if (done) begin
        seen_done = 1;
        check("busy_in_done", busy, 0);
        check("pixels_taken", p, 64);
        start = 1'b0; w_we = 1'b0; in_valid = 1'b0;
      end
      cyc++;
    end
    start = 1'b0; w_we = 1'b0; in_valid = 1'b0;
    if (!seen_done) check("done_timeout", 0, 1);
    if (!rnd) check("latency", out_cyc - acc_cyc, 2);
    @(negedge clk);
    #4;
    check("done_pulse_end", done, 0);
    check("busy_after", busy, 0);
    check("n_out", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) check("out", got[i], exp_q[i]);
  endtask

  initial begin
    int p;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    reset = 1'b1;

    load_w(0);
    exp_ramp(0); run_frame(0, 0, 0, 0, 0);
    exp_ramp(1); run_frame(1, 0, 0, 0, 0);

    load_w(1);
    exp_const(36, 127); run_frame(0, 0, 1, 0, 0);
    load_w(2);
    exp_const(9, -128); run_frame(1, 0, 1, 0, 0);
    exp_const(9, 0);    run_frame(1, 1, 1, 0, 0);

    load_w(0);
    exp_ramp(0); run_frame(0, 0, 0, 1, 1);
    exp_ramp(0); run_frame(0, 0, 0, 0, 0);

    // abort mid-frame
    @(negedge clk);
    start = 1'b1; stride2 = 1'b0; relu_en = 1'b0;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1; p = 0;
    for (int g = 0; g < 200 && p < 20; g++) begin
      in_valid = 1'b1; in_data = p[7:0];
      #4;
      if (in_valid && in_ready) p++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #4 check("abort_no_done", done, 0);
    end

    exp_const(36, 0); run_frame(0, 0, 0, 0, 0);
    load_w(0);
    exp_ramp(0); run_frame(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_stream_engine.md
Name: conv_stream_engine

Overview:
- Parametrised streaming successor to the fixed-size cnn_accelerator convolution core.
- Accepts an IMG_H x IMG_W unsigned feature map one pixel per handshake in raster order.
- Holds a runtime-loadable signed KxK kernel and emits signed, scaled, saturated convolution results on a valid/ready stream.
- Supports stride 1/2 and optional ReLU; sits between the ifmap DMA/loader and the pooling stage.

Parameters:
- DATA_WIDTH, 8: pixel, weight and output width.
- IMG_W, 8: image width in pixels (>= K).
- IMG_H, 8: image height in rows (>= K).
- K, 3: kernel size, odd, 1..7.
- ACC_WIDTH, 24: accumulator width; must hold K*K*(2^DATA_WIDTH-1)*2^(DATA_WIDTH-1) plus sign.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a frame; sampled in IDLE only.
- stride2  in  1  latched at start; 1 selects stride 2.
- relu_en  in  1  latched at start; 1 clamps negative results to 0.
- w_we  in  1  weight write strobe; ignored while busy.
- w_addr  in  $clog2(K*K)  weight index r*K+c; values >= K*K are ignored.
- w_data  in  DATA_WIDTH  signed weight.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  unsigned pixel.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_WIDTH  signed result.
- busy  out  1  high from the start-accept cycle until done.
- done  out  1  one-cycle pulse after the last output handshake.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - in_ready, out_valid, busy, done = 0; out_data = 0.
  - All weights, line buffers and counters = 0.
- FSM states:
  - IDLE: start=1 -> STREAM. Latch stride2 and relu_en, clear row/col/output counters, busy=1 from the next cycle.
  - STREAM: accept pixels. When pixel IMG_H*IMG_W-1 is accepted -> DRAIN.
  - DRAIN: in_ready=0. Wait until the pipeline is empty and the final output has handshaken -> DONE.
  - DONE: done=1 for one cycle, busy=0, then -> IDLE.
- Line buffers: K-1 rows of IMG_W pixels plus a KxK window register. The window shifts on every accepted pixel; col wraps to 0 at IMG_W-1 and row then increments.
- Window emission: a window is valid when the accepted pixel has row>=K-1 and col>=K-1.
  - With stride2, additionally (row-(K-1)) and (col-(K-1)) must both be even.
  - Output count per frame: OUT_H*OUT_W, where OUT_W=(IMG_W-K)/S+1 and OUT_H=(IMG_H-K)/S+1.
- Arithmetic:
  - acc = sum over r,c of zero-extended window[r][c] times signed w[r*K+c].
  - window[0][0] is the oldest (top-left) pixel.
  - Apply an arithmetic shift right by SHIFT.
  - If relu_en and acc<0, the result is 0.
  - Saturate to the signed range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Pipeline:
  - Stage 1: registered products. Stage 2: registered sum and post-processing into the output register.
  - Latency is 2 cycles from the accepting handshake to out_valid, with no stall.
  - Invalid windows enter the pipeline as bubbles.
- Backpressure:
  - stall = out_valid && !out_ready.
  - While stall, pipeline stages and out_data hold.
  - in_ready = (state==STREAM) && !stall.
  - out_data stays stable while out_valid && !out_ready.
- Weights: writable only in IDLE/DONE. w_we while busy has no effect. Weights persist across frames.
- start while busy is ignored. Pixels with in_valid outside STREAM are not consumed.
- A reset assertion mid-frame aborts immediately; no done pulse is produced. The next start runs a clean frame.

Test Plan:
- Identity kernel (w[4]=1, others 0), K=3, 8x8 ramp pixel value = row*8+col, stride 1, SHIFT=0 -> 36 outputs equal to the interior pixels 9,10,...,14,17,...,54 in order, then one done pulse.
- Same setup with stride2=1 -> 9 outputs: 9,11,13,25,27,29,41,43,45.
- All-ones kernel, all pixels 255 -> every output saturates to 127. Kernel of all -1 -> -128 with relu_en=0, 0 with relu_en=1.
- Identity kernel, out_ready random at 50% and in_valid random -> the identical 36-value sequence: no loss, no duplicates, out_data stable while stalled.
- Weight write with w_we during STREAM -> ignored. A second frame uses the original weights and matches the first frame's outputs.
- reset pulled low after 20 pixels -> out_valid=0, busy=0, in_ready=0 asynchronously. A following full frame yields the correct 36 outputs and done.
